// File: rtl/conv3x3_engine.sv
// conv3x3_engine: streaming 3x3 convolution over a raster pixel stream.
// Two line buffers plus a 3x3 window feed a fixed 3-stage multiply/sum/post
// pipeline that never stalls. Coefficients are double-buffered so that a new
// kernel (with its shift and mode) takes effect cleanly at frame start.
module conv3x3_engine #(
  parameter int DW    = 12,
  parameter int CW    = 8,
  parameter int IMG_W = 1280,
  parameter int IMG_H = 960
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic          iSOF,
  input  logic          iCOEF_WE,
  input  logic [3:0]    iCOEF_ADDR,
  input  logic [CW-1:0] iCOEF_DATA,
  input  logic [3:0]    iSHIFT,
  input  logic          iMODE,
  output logic          oDVAL,
  output logic [DW-1:0] oDATA,
  output logic          oEOF
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = DW + CW + 1;
  localparam int SW = DW + CW + 5;
  localparam logic signed [SW-1:0] MAX_PIX = {{(SW-DW){1'b0}}, {DW{1'b1}}};

  logic          accept;
  logic          sofAccept;
  logic [XW-1:0] xCnt;
  logic [YW-1:0] yCnt;
  logic [XW-1:0] xPos;
  logic [YW-1:0] yPos;

  logic signed [CW-1:0] shadowCoef [9];
  logic signed [CW-1:0] activeCoef [9];
  logic [3:0]           activeShift;
  logic                 activeMode;

  logic [DW-1:0] lineBuf0 [IMG_W];
  logic [DW-1:0] lineBuf1 [IMG_W];
  logic [DW-1:0] win [9];

  logic                 validA, borderA, eofA;
  logic                 validB, borderB, eofB;
  logic signed [PW-1:0] prodB [9];
  logic [3:0]           shiftB;
  logic                 modeB;
  logic                 validC, borderC, eofC;
  logic signed [SW-1:0] sumC;
  logic [3:0]           shiftC;
  logic                 modeC;

  logic signed [SW-1:0] sumComb;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] magnitude;
  logic [DW-1:0]        satPix;

  // A start-of-frame pixel is always treated as (0,0), whatever the counters say.
  assign accept    = iDVAL && !iRST;
  assign sofAccept = accept && iSOF;
  assign xPos      = sofAccept ? '0 : xCnt;
  assign yPos      = sofAccept ? '0 : yCnt;

  // Raster position counters, advanced once per accepted pixel.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (iDVAL) begin
      if (xPos == XW'(IMG_W - 1)) begin
        xCnt <= '0;
        yCnt <= (yPos == YW'(IMG_H - 1)) ? '0 : yPos + YW'(1);
      end else begin
        xCnt <= xPos + XW'(1);
        yCnt <= yPos;
      end
    end
  end

  // Shadow/active coefficient banks; the active set reads the shadow value from before any same-cycle write.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < 9; i++) begin
        shadowCoef[i] <= (i == 4) ? CW'(1) : '0;
        activeCoef[i] <= (i == 4) ? CW'(1) : '0;
      end
      activeShift <= '0;
      activeMode  <= 1'b0;
    end else begin
      if (sofAccept) begin
        activeCoef  <= shadowCoef;
        activeShift <= iSHIFT;
        activeMode  <= iMODE;
      end
      if (iCOEF_WE && (iCOEF_ADDR <= 4'd8)) begin
        shadowCoef[iCOEF_ADDR] <= $signed(iCOEF_DATA);
      end
    end
  end

  // Line buffers and window move only on accepted pixels; stale contents are hidden by border masking.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lineBuf1[xPos] <= lineBuf0[xPos];
      lineBuf0[xPos] <= iDATA;
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= lineBuf1[xPos];
      win[5] <= lineBuf0[xPos];
      win[8] <= iDATA;
    end
  end

  // Stage A: tag the freshly shifted window with validity, border and end-of-frame flags.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      validA  <= 1'b0;
      borderA <= 1'b0;
      eofA    <= 1'b0;
    end else begin
      validA <= accept;
      if (accept) begin
        borderA <= (xPos < XW'(2)) || (yPos < YW'(2));
        eofA    <= (xPos == XW'(IMG_W - 1)) && (yPos == YW'(IMG_H - 1));
      end
    end
  end

  // Stage B: nine unsigned-by-signed products; shift and mode travel with the data from here on.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      validB <= 1'b0;
    end else begin
      validB <= validA;
      if (validA) begin
        for (int i = 0; i < 9; i++) begin
          prodB[i] <= PW'($signed({1'b0, win[i]})) * PW'(activeCoef[i]);
        end
        borderB <= borderA;
        eofB    <= eofA;
        shiftB  <= activeShift;
        modeB   <= activeMode;
      end
    end
  end

  // Signed sum of the products at full width so it cannot overflow.
  always_comb begin
    sumComb = '0;
    for (int i = 0; i < 9; i++) begin
      sumComb = sumComb + SW'(prodB[i]);
    end
  end

  // Stage C: register the sum alongside its tags.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      validC <= 1'b0;
    end else begin
      validC <= validB;
      if (validB) begin
        sumC    <= sumComb;
        borderC <= borderB;
        eofC    <= eofB;
        shiftC  <= shiftB;
        modeC   <= modeB;
      end
    end
  end

  // Arithmetic shift, then absolute value or negative clamp, then saturation to the pixel range.
  always_comb begin
    shifted = sumC >>> shiftC;
    if (shifted[SW-1]) begin
      magnitude = modeC ? '0 : -shifted;
    end else begin
      magnitude = shifted;
    end
    if (magnitude > MAX_PIX) begin
      satPix = '1;
    end else begin
      satPix = magnitude[DW-1:0];
    end
  end

  // Output register; data holds its last value between valid outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oEOF  <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= validC;
      oEOF  <= validC && eofC;
      if (validC) begin
        oDATA <= borderC ? '0 : satPix;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb_conv3x3_engine: drives directed and randomized frames into conv3x3_engine
// and compares every output cycle against a frame-array reference model.
module tb_conv3x3_engine;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int NONE  = 1 << 30;

  logic          iCLK       = 1'b0;
  logic          iRST       = 1'b0;
  logic          iDVAL      = 1'b0;
  logic [DW-1:0] iDATA      = '0;
  logic          iSOF       = 1'b0;
  logic          iCOEF_WE   = 1'b0;
  logic [3:0]    iCOEF_ADDR = '0;
  logic [CW-1:0] iCOEF_DATA = '0;
  logic [3:0]    iSHIFT     = '0;
  logic          iMODE      = 1'b0;
  logic          oDVAL;
  logic [DW-1:0] oDATA;
  logic          oEOF;

  typedef struct packed {
    int            due;
    int            x;
    int            y;
    logic [DW-1:0] data;
    logic          eof;
  } expect_t;

  typedef struct packed {
    logic [3:0]    addr;
    logic [CW-1:0] data;
  } write_t;

  expect_t expQ [$];
  write_t  wrQ [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checking = 0;
  bit rstEdge = 0;
  int outCount = 0;
  int eofCount = 0;
  logic [DW-1:0] lastData = '0;

  logic [DW-1:0] frameMem [IMG_H][IMG_W];
  logic [DW-1:0] outImg [IMG_H][IMG_W];
  int shCoef [9];
  int actCoef [9];
  int actShift = 0;
  int actMode = 0;
  int mx = 0;
  int my = 0;

  conv3x3_engine #(.DW(DW), .CW(CW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iDVAL(iDVAL),
    .iDATA(iDATA),
    .iSOF(iSOF),
    .iCOEF_WE(iCOEF_WE),
    .iCOEF_ADDR(iCOEF_ADDR),
    .iCOEF_DATA(iCOEF_DATA),
    .iSHIFT(iSHIFT),
    .iMODE(iMODE),
    .oDVAL(oDVAL),
    .oDATA(oDATA),
    .oEOF(oEOF)
  );

  // Free-running clock.
  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Direct 3x3 convolution over the stored frame, followed by shift, mode and saturation.
  function automatic int modelPixel(input int x, input int y);
    longint acc = 0;
    if (x < 2 || y < 2) return 0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        acc += longint'(frameMem[y-2+dy][x-2+dx]) * longint'(actCoef[dy*3+dx]);
      end
    end
    acc = acc >>> actShift;
    if (actMode == 0) begin
      if (acc < 0) acc = -acc;
    end else if (acc < 0) begin
      acc = 0;
    end
    if (acc > 255) acc = 255;
    return int'(acc);
  endfunction

  // Reference model: observes the inputs at each sampling edge and queues the expected output.
  initial begin
    forever begin
      @(posedge iCLK);
      cyc++;
      rstEdge = iRST;
      if (iRST) begin
        expQ.delete();
        mx = 0;
        my = 0;
        for (int i = 0; i < 9; i++) begin
          shCoef[i]  = (i == 4) ? 1 : 0;
          actCoef[i] = (i == 4) ? 1 : 0;
        end
        actShift = 0;
        actMode  = 0;
      end else begin
        if (iDVAL) begin
          expect_t e;
          if (iSOF) begin
            mx = 0;
            my = 0;
            actCoef  = shCoef;
            actShift = int'(iSHIFT);
            actMode  = int'(iMODE);
          end
          frameMem[my][mx] = iDATA;
          e.due  = cyc + 3;
          e.x    = mx;
          e.y    = my;
          e.data = DW'(modelPixel(mx, my));
          e.eof  = (mx == IMG_W - 1) && (my == IMG_H - 1);
          expQ.push_back(e);
          mx++;
          if (mx == IMG_W) begin
            mx = 0;
            my = (my == IMG_H - 1) ? 0 : my + 1;
          end
        end
        if (iCOEF_WE && (iCOEF_ADDR <= 4'd8)) begin
          shCoef[iCOEF_ADDR] = int'($signed(iCOEF_DATA));
        end
      end
    end
  end

  // Compare process: every cycle the DUT must either deliver the queued output or stay idle holding data.
  initial begin
    forever begin
      @(negedge iCLK);
      if (rstEdge) begin
        checking = 1;
        lastData = '0;
      end
      if (checking) begin
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
          expect_t e;
          e = expQ.pop_front();
          checkOutput("out_dval", int'(oDVAL), 1);
          checkOutput($sformatf("out_data(%0d,%0d)", e.x, e.y), int'(oDATA), int'(e.data));
          checkOutput("out_eof", int'(oEOF), int'(e.eof));
          outImg[e.y][e.x] = oDATA;
          lastData = e.data;
        end else begin
          checkOutput("idle_dval", int'(oDVAL), 0);
          checkOutput("idle_eof", int'(oEOF), 0);
          checkOutput("hold_data", int'(oDATA), int'(lastData));
        end
        if (oDVAL) outCount++;
        if (oEOF) eofCount++;
      end
    end
  end

  task automatic applyStimulus(input bit dval, input bit sof, input int data, input bit we,
                               input int addr, input int cdata, input int shiftV, input int modeV);
    iDVAL      = dval;
    iSOF       = sof;
    iDATA      = DW'(data);
    iCOEF_WE   = we;
    iCOEF_ADDR = 4'(addr);
    iCOEF_DATA = CW'(cdata);
    iSHIFT     = 4'(shiftV);
    iMODE      = 1'(modeV);
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 1'($urandom_range(1)), $urandom_range(255), 0, 0, 0,
                    $urandom_range(15), $urandom_range(1));
    end
  endtask

  task automatic doReset(input int n);
    iRST = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(255), 0, 0, 0,
                    $urandom_range(15), $urandom_range(1));
    end
    iRST = 1'b0;
  endtask

  task automatic setKernel(input int k);
    int sobel [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    write_t w;
    for (int i = 0; i < 9; i++) begin
      w.addr = 4'(i);
      case (k)
        0:       w.data = (i == 4) ? CW'(1) : '0;
        1:       w.data = CW'(sobel[i]);
        2:       w.data = (i == 4) ? CW'(-1) : '0;
        3:       w.data = '0;
        default: w.data = CW'($urandom_range(255));
      endcase
      wrQ.push_back(w);
      if (k == 4 && $urandom_range(3) == 0) begin
        w.addr = 4'($urandom_range(15, 9));
        w.data = CW'($urandom_range(255));
        wrQ.push_back(w);
      end
    end
  endtask

  task automatic flushWrites();
    while (wrQ.size() > 0) begin
      write_t w;
      w = wrQ.pop_front();
      applyStimulus(0, 1'($urandom_range(1)), $urandom_range(255), 1, int'(w.addr),
                    int'($signed(w.data)), $urandom_range(15), $urandom_range(1));
    end
  endtask

  function automatic int pixVal(input int kind, input int x, input int y);
    case (kind)
      0:       return x + 8 * y;
      1:       return 100;
      2:       return (x < 4) ? 0 : 200;
      3:       return 50;
      default: return int'($urandom_range(255));
    endcase
  endfunction

  // gap: 0 continuous, 1 every other cycle, 2 random 0..2 idle cycles between pixels.
  task automatic sendFrame(input int kind, input int gap, input int shiftV, input int modeV,
                           input int wrStart, input int count);
    for (int idx = 0; idx < count; idx++) begin
      bit we;
      write_t w;
      we = 0;
      w  = '0;
      if (idx >= wrStart && wrQ.size() > 0) begin
        we = 1;
        w  = wrQ.pop_front();
      end
      applyStimulus(1, idx == 0, pixVal(kind, idx % IMG_W, idx / IMG_W), we, int'(w.addr),
                    int'($signed(w.data)),
                    (idx == 0) ? shiftV : int'($urandom_range(15)),
                    (idx == 0) ? modeV : int'($urandom_range(1)));
      if (gap == 1) idle(1);
      else if (gap == 2) idle($urandom_range(2));
    end
  endtask

  task automatic clearStats();
    outCount = 0;
    eofCount = 0;
  endtask

  // Safety net in case the stimulus ever stops making progress.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed scenarios followed by randomized frames.
  initial begin
    doReset(2);
    checkOutput("reset_dval", int'(oDVAL), 0);
    checkOutput("reset_data", int'(oDATA), 0);
    checkOutput("reset_eof", int'(oEOF), 0);

    $display("[TB] identity after reset");
    clearStats();
    sendFrame(0, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("ident_7_5", int'(outImg[5][7]), 38);
    checkOutput("ident_2_2", int'(outImg[2][2]), 9);
    checkOutput("ident_border_1_4", int'(outImg[4][1]), 0);
    checkOutput("ident_count", outCount, 48);
    checkOutput("ident_eof_count", eofCount, 1);

    $display("[TB] sobel-x");
    setKernel(1);
    flushWrites();
    sendFrame(1, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("sobel_flat_4_3", int'(outImg[3][4]), 0);
    sendFrame(2, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("sobel_edge_4_2", int'(outImg[2][4]), 255);
    checkOutput("sobel_edge_5_2", int'(outImg[2][5]), 255);
    checkOutput("sobel_left_3_2", int'(outImg[2][3]), 0);
    checkOutput("sobel_right_6_2", int'(outImg[2][6]), 0);

    $display("[TB] negative centre, modes and shift");
    setKernel(2);
    flushWrites();
    sendFrame(3, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("neg_abs", int'(outImg[3][3]), 50);
    sendFrame(3, 0, 0, 1, NONE, 48);
    idle(5);
    checkOutput("neg_clamp", int'(outImg[3][3]), 0);
    sendFrame(3, 0, 1, 0, NONE, 48);
    idle(5);
    checkOutput("neg_shift1", int'(outImg[3][3]), 25);

    $display("[TB] coefficient writes during a frame");
    setKernel(0);
    flushWrites();
    sendFrame(0, 0, 0, 0, NONE, 48);
    setKernel(3);
    sendFrame(0, 0, 0, 0, 10, 48);
    idle(5);
    checkOutput("midwr_cur_7_5", int'(outImg[5][7]), 38);
    checkOutput("midwr_cur_4_3", int'(outImg[3][4]), 19);
    sendFrame(0, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("midwr_next_7_5", int'(outImg[5][7]), 0);
    setKernel(0);
    flushWrites();
    sendFrame(0, 0, 0, 0, NONE, 48);
    begin
      write_t w;
      w.addr = 4'd4;
      w.data = '0;
      wrQ.push_back(w);
    end
    sendFrame(0, 0, 0, 0, 0, 48);
    idle(5);
    checkOutput("sofwr_same_7_5", int'(outImg[5][7]), 38);
    sendFrame(0, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("sofwr_next_7_5", int'(outImg[5][7]), 0);

    $display("[TB] every-other-cycle input");
    setKernel(0);
    flushWrites();
    clearStats();
    sendFrame(0, 1, 0, 0, NONE, 48);
    idle(5);
    checkOutput("gap_7_5", int'(outImg[5][7]), 38);
    checkOutput("gap_count", outCount, 48);

    $display("[TB] reset mid-frame");
    setKernel(1);
    flushWrites();
    sendFrame(0, 0, 0, 0, NONE, 20);
    doReset(1);
    idle(6);
    clearStats();
    sendFrame(0, 0, 0, 0, NONE, 48);
    idle(5);
    checkOutput("rst_7_5", int'(outImg[5][7]), 38);
    checkOutput("rst_3_2", int'(outImg[2][3]), 10);
    checkOutput("rst_count", outCount, 48);
    checkOutput("rst_eof_count", eofCount, 1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      setKernel(4);
      if (f % 2 == 1) begin
        sendFrame(4, 2, $urandom_range(15), $urandom_range(1), NONE, $urandom_range(40, 5));
      end
      sendFrame(4, 2, $urandom_range(15), $urandom_range(1), $urandom_range(47), 48);
      flushWrites();
      idle(4);
    end

    idle(6);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
